// File: rtl/spi_pkg.sv
// Shared definitions for the SPI debug link: frame layout, master FSM
// state encoding and the debug register map used by master, slave and
// debug unit alike.
package spi_pkg;

    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 1 + ADDR_BITS + DATA_BITS;

    // Frame bit positions, MSB first on the wire: {rw, addr, data}
    localparam int RW_POS   = FRAME_BITS - 1;
    localparam int ADDR_MSB = FRAME_BITS - 2;
    localparam int ADDR_LSB = DATA_BITS;
    localparam int DATA_MSB = DATA_BITS - 1;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // Debug register file map
    localparam logic [ADDR_BITS-1:0] ADDR_FORCE_COEF0 = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_FORCE_COEF1 = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_FORCE_COEF2 = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_FORCE_COEF3 = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_MON_COEF0   = 7'h10;
    localparam logic [ADDR_BITS-1:0] ADDR_MON_COEF1   = 7'h11;
    localparam logic [ADDR_BITS-1:0] ADDR_ENABLE      = 7'h20;
    localparam logic [ADDR_BITS-1:0] ADDR_DEBUG_LOAD  = 7'h21;

endpackage

// File: rtl/spi_master_mode0_if.sv
// Request/response handshake plus SPI pins of the mode-0 master.
// The master modport is the view of spi_master_mode0; the slave modport
// is the view of whoever drives requests and models the SPI target.
interface spi_master_mode0_if #(
    parameter int ADDR_BITS = spi_pkg::ADDR_BITS,
    parameter int DATA_BITS = spi_pkg::DATA_BITS
);

    logic                 i_start;
    logic                 i_rw;
    logic [ADDR_BITS-1:0] i_addr;
    logic [DATA_BITS-1:0] i_wdata;
    logic                 o_busy;
    logic                 o_done;
    logic [DATA_BITS-1:0] o_rdata;
    logic                 spi_ss_n;
    logic                 spi_sclk;
    logic                 spi_mosi;
    logic                 spi_miso;

    modport master (
        input  i_start, i_rw, i_addr, i_wdata, spi_miso,
        output o_busy, o_done, o_rdata, spi_ss_n, spi_sclk, spi_mosi
    );

    modport slave (
        output i_start, i_rw, i_addr, i_wdata, spi_miso,
        input  o_busy, o_done, o_rdata, spi_ss_n, spi_sclk, spi_mosi
    );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1, flags the last count,
// and restarts from 0 whenever the FSM enters a new state.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clkA,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Free-running modulo-D counter, forced back to 0 on restart
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/spi_master_mode0.sv
// SPI mode-0 master issuing single {rw, addr, data} frames to the debug
// slave. SCLK idles low, MOSI changes as SCLK falls, MISO is sampled on
// the same clkA edge that drops SCLK.
module spi_master_mode0 #(
    parameter int ADDR_BITS = spi_pkg::ADDR_BITS,
    parameter int DATA_BITS = spi_pkg::DATA_BITS,
    parameter int CLK_DIV   = 2
) (
    input logic                clkA,
    input logic                reset,
    spi_master_mode0_if.master bus
);

    import spi_pkg::*;

    localparam int FRAME_W = 1 + ADDR_BITS + DATA_BITS;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    spi_state_t           state;
    spi_state_t           state_next;
    logic [FRAME_W-1:0]   shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 sclk_high;
    logic                 rw_q;
    logic                 tick;
    logic                 restart;
    logic                 shift_edge;
    logic                 gap_entry;
    logic [DATA_BITS-1:0] wdata_field;
    logic                 done_q;
    logic [DATA_BITS-1:0] rdata_q;

    assign restart     = (state_next != state);
    assign shift_edge  = (state == ST_SHIFT) && sclk_high && tick;
    assign gap_entry   = (state == ST_HOLD) && (state_next == ST_GAP);
    assign wdata_field = bus.i_rw ? bus.i_wdata : {DATA_BITS{1'b0}};

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clkA    (clkA),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // State register
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and SPI pin / busy decoding
    always_comb begin
        state_next   = state;
        bus.o_busy   = 1'b1;
        bus.spi_ss_n = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.o_busy   = 1'b0;
                bus.spi_ss_n = 1'b1;
                if (bus.i_start) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bus.spi_mosi = shreg[FRAME_W-1];
                if (tick) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus.spi_mosi = shreg[FRAME_W-1];
                bus.spi_sclk = sclk_high;
                if (tick && !sclk_high && bit_cnt == LAST_BIT) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                bus.spi_ss_n = 1'b1;
                if (tick) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                bus.o_busy   = 1'b0;
                bus.spi_ss_n = 1'b1;
            end
        endcase
    end

    // Frame shift register, SCLK phase and completed-period counter
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            rw_q      <= 1'b0;
            sclk_high <= 1'b1;
            bit_cnt   <= '0;
        end else begin
            if (state == ST_IDLE && bus.i_start) begin
                shreg <= {bus.i_rw, bus.i_addr, wdata_field};
                rw_q  <= bus.i_rw;
            end else if (shift_edge) begin
                shreg <= {shreg[FRAME_W-2:0], bus.spi_miso};
            end
            if (state != ST_SHIFT) begin
                sclk_high <= 1'b1;
                bit_cnt   <= '0;
            end else if (tick) begin
                sclk_high <= !sclk_high;
                if (!sclk_high) begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

    // Completion pulse and read-data capture on the first GAP cycle
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= gap_entry;
            if (gap_entry && !rw_q) begin
                rdata_q <= shreg[DATA_BITS-1:0];
            end
        end
    end

    assign bus.o_done  = done_q;
    assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_mode0.sv
// Bench for spi_master_mode0: a register-file mode-0 slave on the wire,
// and a transaction-level model of the register file and read data.
module tb_spi_master_mode0;

    localparam int D = 2;

    logic clkA;
    logic reset;
    int   total;
    int   bad;

    logic [7:0]  exp_mem   [128];
    logic [7:0]  slave_mem [128];
    logic [7:0]  exp_rdata;

    int          slave_bits;
    logic [15:0] slave_rx;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;

    spi_master_mode0_if bus ();

    spi_master_mode0 #(.CLK_DIV(D)) dut (
        .clkA  (clkA),
        .reset (reset),
        .bus   (bus)
    );

    initial clkA = 1'b0;
    always #5 clkA = ~clkA;

    // Slave: capture MOSI on each SCLK rise, restart on select
    always @(posedge bus.spi_sclk or negedge bus.spi_ss_n) begin
        if (bus.spi_sclk) begin
            slave_rx   = {slave_rx[14:0], bus.spi_mosi};
            slave_bits = slave_bits + 1;
            if (slave_bits == 8) begin
                cmd_rw   = slave_rx[7];
                cmd_addr = slave_rx[6:0];
            end
            if (slave_bits == 16 && cmd_rw) begin
                slave_mem[cmd_addr] = slave_rx[7:0];
            end
        end else begin
            slave_bits = 0;
            slave_rx   = '0;
        end
    end

    // Slave: present the next MISO bit shortly after SCLK falls
    always @(negedge bus.spi_sclk or posedge bus.spi_ss_n) begin
        logic [7:0] tmp;
        #1;
        if (bus.spi_ss_n || slave_bits < 8 || slave_bits >= 16 || cmd_rw) begin
            bus.spi_miso = 1'b0;
        end else begin
            tmp = slave_mem[cmd_addr];
            bus.spi_miso = tmp[15 - slave_bits];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One frame from request to return to idle, with optional stray start pulse
    task automatic applyStimulus(input logic rw, input logic [6:0] addr,
                                 input logic [7:0] wdata, input int pulse_cyc);
        logic [15:0] exp_frame;
        logic [7:0]  rdata_at_done;
        int cyc, first_rise, done_cyc, done_cnt, idle_cyc;
        logic prev_sclk;
        exp_frame = {rw, addr, (rw ? wdata : 8'h00)};
        if (rw) exp_mem[addr] = wdata;
        else    exp_rdata     = exp_mem[addr];
        bus.i_rw    = rw;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        bus.i_start = 1'b1;
        @(posedge clkA); #1;
        cyc = 1;
        bus.i_start = 1'b0;
        checkOutput("busy_c1", 32'(bus.o_busy), 1);
        checkOutput("ssn_c1", 32'(bus.spi_ss_n), 0);
        checkOutput("mosi_c1", 32'(bus.spi_mosi), 32'(exp_frame[15]));
        first_rise = -1; done_cyc = -1; done_cnt = 0; idle_cyc = -1;
        prev_sclk = 1'b0; rdata_at_done = 8'h00;
        while (idle_cyc < 0 && cyc < 40*D + 20) begin
            if (bus.spi_sclk && !prev_sclk && first_rise < 0) first_rise = cyc;
            if (bus.o_done) begin
                done_cnt++;
                done_cyc = cyc;
                rdata_at_done = bus.o_rdata;
            end
            if (!bus.o_busy) idle_cyc = cyc;
            prev_sclk = bus.spi_sclk;
            if (pulse_cyc > 0 && cyc == pulse_cyc) begin
                bus.i_start = 1'b1;
                bus.i_rw    = ~rw;
                bus.i_addr  = ~addr;
                bus.i_wdata = ~wdata;
            end else begin
                bus.i_start = 1'b0;
            end
            if (idle_cyc < 0) begin
                @(posedge clkA); #1;
                cyc++;
            end
        end
        checkOutput("first_rise", 32'(first_rise), 32'(1 + D));
        checkOutput("done_cycle", 32'(done_cyc), 32'(1 + 34*D));
        checkOutput("busy_low", 32'(idle_cyc), 32'(1 + 35*D));
        checkOutput("done_count", 32'(done_cnt), 1);
        checkOutput("rdata", 32'(rdata_at_done), 32'(exp_rdata));
        checkOutput("mosi_frame", 32'(slave_rx), 32'(exp_frame));
        checkOutput("sclk_rises", 32'(slave_bits), 16);
    endtask

    // Back-to-back writes with start held high across the deselect gap
    task automatic runHeld(input logic [6:0] addr, input logic [7:0] wdata);
        int cyc, rise_cyc, fall_cyc, done_cnt;
        logic prev_ssn;
        exp_mem[addr] = wdata;
        bus.i_rw    = 1'b1;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        bus.i_start = 1'b1;
        @(posedge clkA); #1;
        cyc = 1; rise_cyc = -1; fall_cyc = -1; done_cnt = 0;
        prev_ssn = bus.spi_ss_n;
        while (cyc < 70*D + 8) begin
            if (bus.o_done) done_cnt++;
            if (bus.spi_ss_n && !prev_ssn && rise_cyc < 0) rise_cyc = cyc;
            if (!bus.spi_ss_n && prev_ssn && rise_cyc >= 0 && fall_cyc < 0) begin
                fall_cyc = cyc;
                bus.i_start = 1'b0;
            end
            prev_ssn = bus.spi_ss_n;
            @(posedge clkA); #1;
            cyc++;
        end
        bus.i_start = 1'b0;
        checkOutput("held_ssn_rise", 32'(rise_cyc), 32'(1 + 34*D));
        checkOutput("held_deselect", 32'(fall_cyc - rise_cyc), 32'(D + 1));
        checkOutput("held_done_count", 32'(done_cnt), 2);
        checkOutput("held_idle", 32'(bus.o_busy), 0);
        checkOutput("held_slave_mem", 32'(slave_mem[addr]), 32'(wdata));
    endtask

    // Abort a read frame with reset at the 7th SCLK high phase
    task automatic runReset(input logic [6:0] addr);
        int n;
        int done_seen;
        bus.i_rw    = 1'b0;
        bus.i_addr  = addr;
        bus.i_wdata = 8'h00;
        bus.i_start = 1'b1;
        @(posedge clkA); #1;
        bus.i_start = 1'b0;
        n = 0;
        while (!(bus.spi_sclk && slave_bits == 7) && n < 40*D) begin
            @(posedge clkA); #1;
            n++;
        end
        checkOutput("reach_7th_high", 32'(n < 40*D), 1);
        reset = 1'b0;
        #1;
        checkOutput("rst_ssn", 32'(bus.spi_ss_n), 1);
        checkOutput("rst_sclk", 32'(bus.spi_sclk), 0);
        checkOutput("rst_busy", 32'(bus.o_busy), 0);
        checkOutput("rst_rdata", 32'(bus.o_rdata), 0);
        exp_rdata = 8'h00;
        done_seen = 0;
        repeat (3) begin
            @(posedge clkA); #1;
            if (bus.o_done) done_seen++;
        end
        reset = 1'b1;
        repeat (40*D) begin
            @(posedge clkA); #1;
            if (bus.o_done) done_seen++;
        end
        checkOutput("rst_no_done", 32'(done_seen), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         pulse;
        total = 0;
        bad = 0;
        reset = 1'b0;
        bus.i_start = 1'b0;
        bus.i_rw    = 1'b0;
        bus.i_addr  = '0;
        bus.i_wdata = '0;
        bus.spi_miso = 1'b0;
        slave_bits = 0;
        slave_rx = '0;
        cmd_rw = 1'b0;
        cmd_addr = '0;
        exp_rdata = 8'h00;
        for (int i = 0; i < 128; i++) begin
            exp_mem[i]   = 8'($urandom);
            slave_mem[i] = exp_mem[i];
        end
        repeat (3) @(posedge clkA);
        #1;
        checkOutput("reset_ssn", 32'(bus.spi_ss_n), 1);
        checkOutput("reset_sclk", 32'(bus.spi_sclk), 0);
        checkOutput("reset_mosi", 32'(bus.spi_mosi), 0);
        checkOutput("reset_busy", 32'(bus.o_busy), 0);
        checkOutput("reset_done", 32'(bus.o_done), 0);
        checkOutput("reset_rdata", 32'(bus.o_rdata), 0);
        reset = 1'b1;
        @(posedge clkA); #1;

        $display("[TB] directed write / read");
        applyStimulus(1'b1, 7'h05, 8'hA5, 0);
        exp_mem[7'h12] = 8'h3C;
        slave_mem[7'h12] = 8'h3C;
        applyStimulus(1'b0, 7'h12, 8'h77, 0);

        $display("[TB] loopback through register file");
        applyStimulus(1'b1, spi_pkg::ADDR_FORCE_COEF1, 8'h1B, 0);
        applyStimulus(1'b0, spi_pkg::ADDR_FORCE_COEF1, 8'h00, 0);
        applyStimulus(1'b1, spi_pkg::ADDR_FORCE_COEF0, 8'hC4, 0);

        $display("[TB] start pulse during shift");
        applyStimulus(1'b1, 7'h33, 8'h5A, 20);

        $display("[TB] start held for two frames");
        runHeld(7'h21, 8'h96);

        $display("[TB] reset mid-frame");
        runReset(7'h12);
        @(posedge clkA); #1;
        applyStimulus(1'b0, 7'h05, 8'h00, 0);

        $display("[TB] random frames");
        for (int k = 0; k < 12; k++) begin
            rw    = 1'($urandom);
            addr  = 7'($urandom);
            data  = 8'($urandom);
            pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 34*D)) : 0;
            applyStimulus(rw, addr, data, pulse);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
